// File: rtl/cpu.sv
// FHE ciphertext execution core: q-basis polynomial register file plus a lane-parallel modular add.
// Optional CT-PT add is enabled by defining CPU_CT_PT_ADD_EN; the FSM state is readable as state_q.
package cpu_pkg;
   localparam int N_LANES = 8;
   localparam int COEF_W  = 32;
   localparam logic [1:0] OP_NOP       = 2'd0;
   localparam logic [1:0] OP_CT_CT_ADD = 2'd1;
   localparam logic [1:0] OP_CT_PT_ADD = 2'd2;
   typedef logic [N_LANES-1:0][COEF_W-1:0] q_BASIS_poly;
   typedef struct packed {
      logic [1:0] mode;
      logic [4:0] idx1_a;
      logic [4:0] idx1_b;
      logic [4:0] idx2_a;
      logic [4:0] idx2_b;
      logic [4:0] out_a;
      logic [4:0] out_b;
   } operation;
endpackage

module cpu_rf_q
   import cpu_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int IW       = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IW-1:0]     rd_idx_i [4],
   output q_BASIS_poly       rd_data_o [4],
   input  logic              wa_en_i,
   input  logic [IW-1:0]     wa_idx_i,
   input  q_BASIS_poly       wa_data_i,
   input  logic              wb_en_i,
   input  logic [IW-1:0]     wb_idx_i,
   input  q_BASIS_poly       wb_data_i
);
   localparam int AW = $clog2(NUM_REGS);

   q_BASIS_poly mem [0:NUM_REGS-1];

   always_comb begin
      for (int r = 0; r < 4; r++) begin
         rd_data_o[r] = '0;
         if (32'(rd_idx_i[r]) < NUM_REGS) rd_data_o[r] = mem[rd_idx_i[r][AW-1:0]];
      end
   end

   // Port B is written after port A so it wins when both target one register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
      end else begin
         if (wa_en_i && (32'(wa_idx_i) < NUM_REGS)) mem[wa_idx_i[AW-1:0]] <= wa_data_i;
         if (wb_en_i && (32'(wb_idx_i) < NUM_REGS)) mem[wb_idx_i[AW-1:0]] <= wb_data_i;
      end
   end
endmodule

module cpu
   import cpu_pkg::*;
#(
   parameter int              NUM_REGS = 16,
   parameter int              N        = 8,
   parameter int              W        = 32,
   parameter logic [W-1:0]    Q        = 32'hFFFF_FFFB,
   parameter int unsigned     DELTA    = 16
) (
   input  logic     clk,
   input  logic     reset,
   input  operation op,
   output logic     done_out
);
   typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WB, S_DONE} state_e;

   state_e      state_q, state_d;
   operation    op_q, op_d;
   q_BASIS_poly a1_q, b1_q, a2_q, b2_q;
   q_BASIS_poly a1_d, b1_d, a2_d, b2_d;
   q_BASIS_poly res_a_q, res_b_q, res_a_d, res_b_d;
   logic        done_q, done_d;
   logic        mode_legal, wr_en;
   logic [4:0]  rd_idx [4];
   q_BASIS_poly rd_data [4];

   function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, Q}) s = s - {1'b0, Q};
      return s[W-1:0];
   endfunction

   function automatic logic [W-1:0] mul_delta_mod(input logic [W-1:0] a);
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, a} * (2*W)'(DELTA);
      p = p % {{W{1'b0}}, Q};
      return p[W-1:0];
   endfunction

   cpu_rf_q #(.NUM_REGS(NUM_REGS), .IW(5)) u_rf_q (
      .clk       (clk),
      .reset     (reset),
      .rd_idx_i  (rd_idx),
      .rd_data_o (rd_data),
      .wa_en_i   (wr_en),
      .wa_idx_i  (op_q.out_a),
      .wa_data_i (res_a_q),
      .wb_en_i   (wr_en),
      .wb_idx_i  (op_q.out_b),
      .wb_data_i (res_b_q)
   );

   always_comb begin
      rd_idx[0] = op_q.idx1_a;
      rd_idx[1] = op_q.idx1_b;
      rd_idx[2] = op_q.idx2_a;
      rd_idx[3] = op_q.idx2_b;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (op.mode != OP_NOP) state_d = S_READ;
         S_READ:  state_d = S_EXEC;
         S_EXEC:  state_d = S_WB;
         S_WB:    state_d = S_DONE;
         S_DONE:  if (op.mode == OP_NOP) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mode_legal = (op_q.mode == OP_CT_CT_ADD);
`ifdef CPU_CT_PT_ADD_EN
      mode_legal = mode_legal || (op_q.mode == OP_CT_PT_ADD);
`endif
      wr_en  = (state_q == S_WB) && mode_legal;
      // A held request parks in DONE with done high; it is never replayed.
      done_d = (state_q == S_DONE) && (op.mode != OP_NOP);
   end

   always_comb begin
      op_d    = op_q;
      a1_d    = a1_q;
      b1_d    = b1_q;
      a2_d    = a2_q;
      b2_d    = b2_q;
      res_a_d = res_a_q;
      res_b_d = res_b_q;
      if (state_q == S_IDLE && op.mode != OP_NOP) op_d = op;
      if (state_q == S_READ) begin
         a1_d = rd_data[0];
         b1_d = rd_data[1];
         a2_d = rd_data[2];
         b2_d = rd_data[3];
      end
      if (state_q == S_EXEC) begin
         for (int i = 0; i < N; i++) begin
            res_a_d[i] = add_mod(a1_q[i], a2_q[i]);
            res_b_d[i] = add_mod(b1_q[i], b2_q[i]);
`ifdef CPU_CT_PT_ADD_EN
            if (op_q.mode == OP_CT_PT_ADD) begin
               res_a_d[i] = a1_q[i];
               res_b_d[i] = add_mod(b1_q[i], mul_delta_mod(a2_q[i]));
            end
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q    <= '0;
         a1_q    <= '0;
         b1_q    <= '0;
         a2_q    <= '0;
         b2_q    <= '0;
         res_a_q <= '0;
         res_b_q <= '0;
         done_q  <= 1'b0;
      end else begin
         op_q    <= op_d;
         a1_q    <= a1_d;
         b1_q    <= b1_d;
         a2_q    <= a2_d;
         b2_q    <= b2_d;
         res_a_q <= res_a_d;
         res_b_q <= res_b_d;
         done_q  <= done_d;
      end
   end

   assign done_out = done_q;
endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: a register-file model produces the expected register contents,
// which are queued at issue time and checked when done_out rises.
module tb_cpu;
   import cpu_pkg::*;

   localparam int              NR  = 16;
   localparam int              PW  = N_LANES * COEF_W;
   localparam longint unsigned QV  = 64'hFFFF_FFFB;
   localparam longint unsigned DLT = 16;

   logic     clk = 1'b0;
   logic     reset;
   operation op;
   logic     done_out;

   int n_assert = 0;
   int n_fail   = 0;

   q_BASIS_poly   mdl [NR];
   logic [PW-1:0] exp_q [$];

   cpu dut (
      .clk      (clk),
      .reset    (reset),
      .op       (op),
      .done_out (done_out)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic q_BASIS_poly fill(input logic [COEF_W-1:0] v);
      q_BASIS_poly p;
      for (int i = 0; i < N_LANES; i++) p[i] = v;
      return p;
   endfunction

   function automatic operation mk_op(input logic [1:0] m, input int a1, input int b1,
                                      input int a2, input int b2, input int oa, input int ob);
      operation o;
      o.mode   = m;
      o.idx1_a = 5'(a1);
      o.idx1_b = 5'(b1);
      o.idx2_a = 5'(a2);
      o.idx2_b = 5'(b2);
      o.out_a  = 5'(oa);
      o.out_b  = 5'(ob);
      return o;
   endfunction

   function automatic logic [COEF_W-1:0] addm(input longint unsigned a, input longint unsigned b);
      return COEF_W'((a + b) % QV);
   endfunction

   function automatic q_BASIS_poly model_rd(input logic [4:0] idx);
      if (int'(idx) < NR) return mdl[idx[3:0]];
      return '0;
   endfunction

   function automatic logic [COEF_W-1:0] rnd_coef();
      if ($urandom_range(1, 0) == 1) return $urandom_range(32'hFFFF_FFFA, 32'hFFFF_FF00);
      return $urandom_range(32'hFFFF_FFFA, 0);
   endfunction

   task automatic preload(input int idx, input q_BASIS_poly v);
      dut.u_rf_q.mem[idx] = v;
      mdl[idx] = v;
   endtask

   task automatic check_all_zero(input string tag);
      for (int r = 0; r < NR; r++)
         check($sformatf("%s mem%0d", tag, r), dut.u_rf_q.mem[r], '0);
   endtask

   // Called at a negedge with the DUT idle and op at NOP.
   task automatic issue(input operation o, input string tag, input bit hold);
      q_BASIS_poly a1, b1, a2, b2, ra, rb;
      bit legal;
      int cnt;
      a1 = model_rd(o.idx1_a);
      b1 = model_rd(o.idx1_b);
      a2 = model_rd(o.idx2_a);
      b2 = model_rd(o.idx2_b);
      ra = '0;
      rb = '0;
      legal = 1'b0;
      if (o.mode == OP_CT_CT_ADD) begin
         legal = 1'b1;
         for (int i = 0; i < N_LANES; i++) begin
            ra[i] = addm(a1[i], a2[i]);
            rb[i] = addm(b1[i], b2[i]);
         end
      end
`ifdef CPU_CT_PT_ADD_EN
      if (o.mode == OP_CT_PT_ADD) begin
         legal = 1'b1;
         ra = a1;
         for (int i = 0; i < N_LANES; i++)
            rb[i] = addm(b1[i], (longint'(a2[i]) * DLT) % QV);
      end
`endif
      if (legal) begin
         if (int'(o.out_a) < NR) mdl[o.out_a[3:0]] = ra;
         if (int'(o.out_b) < NR) mdl[o.out_b[3:0]] = rb;
      end
      for (int r = 0; r < NR; r++) exp_q.push_back(mdl[r]);

      op  = o;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (done_out !== 1'b1 && cnt < 20);
      check({tag, " done_out"}, PW'(done_out), PW'(1));
      check({tag, " latency"}, PW'(cnt - 1), PW'(4));
      for (int r = 0; r < NR; r++)
         check($sformatf("%s mem%0d", tag, r), dut.u_rf_q.mem[r], exp_q.pop_front());
      if (!hold) begin
         op = '0;
         @(negedge clk);
         check({tag, " done_out release"}, PW'(done_out), PW'(0));
         check({tag, " state idle"}, PW'(int'(dut.state_q)), PW'(0));
      end
   endtask

   initial begin
      reset = 1'b0;
      op    = '0;
      for (int r = 0; r < NR; r++) mdl[r] = '0;
      repeat (3) @(negedge clk);
      check("reset done_out", PW'(done_out), PW'(0));
      check("reset state", PW'(int'(dut.state_q)), PW'(0));
      check_all_zero("reset");
      reset = 1'b1;
      @(negedge clk);

      // Basic CT-CT add
      preload(0, fill(5));
      preload(1, fill(10));
      preload(2, fill(7));
      preload(3, fill(3));
      issue(mk_op(OP_CT_CT_ADD, 0, 1, 2, 3, 4, 5), "ctct_basic", 1'b0);
      check("ctct_basic mem4 const", dut.u_rf_q.mem[4], fill(12));
      check("ctct_basic mem5 const", dut.u_rf_q.mem[5], fill(13));

      // Modular wrap
      preload(0, fill(32'hFFFF_FFFA));
      preload(2, fill(5));
      issue(mk_op(OP_CT_CT_ADD, 0, 1, 2, 3, 4, 5), "ctct_wrap", 1'b0);
      check("ctct_wrap mem4 const", dut.u_rf_q.mem[4], fill(4));

      // Aliased destinations, then a held request must not re-execute
      preload(0, fill(5));
      preload(2, fill(7));
      issue(mk_op(OP_CT_CT_ADD, 0, 1, 2, 3, 6, 6), "alias", 1'b1);
      check("alias mem6 const", dut.u_rf_q.mem[6], fill(13));
      preload(6, fill(32'h999));
      repeat (3) @(negedge clk);
      check("held done_out", PW'(done_out), PW'(1));
      check("held mem6", dut.u_rf_q.mem[6], fill(32'h999));
      op = '0;
      @(negedge clk);
      check("held release done_out", PW'(done_out), PW'(0));

      // CT-PT add (or illegal when the feature is compiled out)
      preload(0, fill(5));
      preload(1, fill(10));
      preload(4, fill(4));
      preload(8, fill(111));
      preload(9, fill(222));
      issue(mk_op(OP_CT_PT_ADD, 0, 1, 4, 5, 8, 9), "ctpt", 1'b0);
`ifdef CPU_CT_PT_ADD_EN
      check("ctpt mem8 const", dut.u_rf_q.mem[8], fill(5));
      check("ctpt mem9 const", dut.u_rf_q.mem[9], fill(74));
`else
      check("ctpt mem8 const", dut.u_rf_q.mem[8], fill(111));
      check("ctpt mem9 const", dut.u_rf_q.mem[9], fill(222));
`endif

      // Illegal mode encoding: no write
      issue(mk_op(2'd3, 0, 1, 2, 3, 10, 11), "illegal", 1'b0);

      // Out-of-range read reads zero, out-of-range write is dropped
      issue(mk_op(OP_CT_CT_ADD, 20, 1, 2, 3, 17, 12), "oor", 1'b0);

      // Random per-lane operands, including values near Q
      for (int t = 0; t < 3; t++) begin
         for (int r = 0; r < 4; r++) begin
            q_BASIS_poly p;
            for (int i = 0; i < N_LANES; i++) p[i] = rnd_coef();
            preload(r, p);
         end
         issue(mk_op(OP_CT_CT_ADD, $urandom_range(3, 0), $urandom_range(3, 0),
                     $urandom_range(3, 0), $urandom_range(3, 0), 13, 14),
               $sformatf("rand%0d", t), 1'b0);
      end

      // Reset asserted while the datapath is in EXEC
      preload(0, fill(5));
      preload(1, fill(10));
      op = mk_op(OP_CT_CT_ADD, 0, 1, 2, 3, 4, 5);
      @(negedge clk);
      @(negedge clk);
      check("mid reset pre state exec", PW'(int'(dut.state_q)), PW'(2));
      reset = 1'b0;
      #1;
      check("mid reset done_out", PW'(done_out), PW'(0));
      check("mid reset state", PW'(int'(dut.state_q)), PW'(0));
      check_all_zero("mid reset");
      op = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (6) @(negedge clk);
      check("post reset done_out", PW'(done_out), PW'(0));
      check("post reset state", PW'(int'(dut.state_q)), PW'(0));
      check_all_zero("post reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
